// File: rtl/pkt_dispatch_ctrl.sv
// Packet dispatch sequencer: captures one decoded packet, filters it (invalid type,
// locked heartbeat) and pulses the enable of the consumer that must process it.
module pkt_dispatch_ctrl #(
  parameter int WORD_WIDTH     = 16,
  parameter int SETTLE_CYCLES  = 2,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      pkt_valid,
  output logic                      pkt_ready,
  input  logic [2:0]                pkt_type,
  input  logic [WORD_WIDTH-1:0]     pkt_energy,
  input  logic [WORD_WIDTH-1:0]     pkt_destID,
  input  logic [WORD_WIDTH-1:0]     pkt_hops,
  input  logic [WORD_WIDTH-1:0]     pkt_timeslot,
  output logic                      en_MNI,
  output logic                      en_FWD,
  output logic                      en_INV,
  output logic [2:0]                fPktType,
  output logic [WORD_WIDTH-1:0]     energy,
  output logic [WORD_WIDTH-1:0]     destinationID,
  output logic [WORD_WIDTH-1:0]     hops,
  output logic [WORD_WIDTH-1:0]     timeslot,
  output logic                      hb_lock,
  output logic                      busy,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DECODE, ISSUE, SETTLE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic             accept;
  logic             drop;

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic type_valid(input logic [2:0] t);
    case (t)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  assign accept = pkt_valid && pkt_ready;
  // Heartbeats are dropped while a previous heartbeat still holds the lock
  assign drop   = !type_valid(fPktType) || ((fPktType == 3'b000) && hb_lock);
  assign busy   = ~pkt_ready;

  always_ff @(posedge clk) begin
    if (nrst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pkt_ready = 1'b0;
    en_MNI    = 1'b0;
    en_FWD    = 1'b0;
    en_INV    = 1'b0;
    case (state)
      IDLE: begin
        pkt_ready = 1'b1;
        if (pkt_valid) state_nxt = DECODE;
      end
      DECODE: state_nxt = drop ? IDLE : ISSUE;
      ISSUE: begin
        case (fPktType)
          3'b000, 3'b001, 3'b100: en_MNI = 1'b1;
          3'b010:                 en_INV = 1'b1;
          3'b101: begin
            en_MNI = 1'b1;
            en_FWD = 1'b1;
          end
          default: ;
        endcase
        state_nxt = SETTLE;
      end
      SETTLE: if (settle_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      fPktType      <= 3'b111;
      energy        <= '0;
      destinationID <= '0;
      hops          <= '0;
      timeslot      <= '0;
      hb_lock       <= 1'b0;
      drop_count    <= '0;
      settle_cnt    <= '0;
    end else begin
      if (accept) begin
        fPktType      <= pkt_type;
        energy        <= pkt_energy;
        destinationID <= pkt_destID;
        hops          <= pkt_hops;
        timeslot      <= pkt_timeslot;
      end
      if ((state == DECODE) && drop) drop_count <= sat_inc(drop_count);
      if (state == ISSUE) begin
        settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
        if (fPktType == 3'b000)      hb_lock <= 1'b1;
        else if (fPktType == 3'b101) hb_lock <= 1'b0;
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
    end
  end

endmodule

// File: doc/pkt_dispatch_ctrl.md
Name: pkt_dispatch_ctrl

Overview:
Sequencer between the receive-side packet buffer and the node-state datapath: myNodeInfo, the forwarding unit and the invite handler. It accepts one decoded packet at a time over a valid/ready handshake and registers its fields. It classifies the packet by type, applies heartbeat-lock filtering, and issues a single-cycle enable to the proper consumer. It then holds off new packets for a settle window so the consumer can update.

Parameters:
WORD_WIDTH, 16, width of energy/destinationID/hops/timeslot fields
SETTLE_CYCLES, 2, cycles pkt_ready stays low after the enable pulse (>=1)
DROP_CNT_WIDTH, 8, width of saturating dropped-packet counter

Ports:
clk  in  1  system clock, rising edge
nrst  in  1  synchronous reset, active-high (sampled on clk rising edge)
pkt_valid  in  1  upstream packet fields valid
pkt_ready  out  1  block can accept a packet
pkt_type  in  3  packet type: 000 HB, 001 CHE, 010 INV, 100 CHTimeslot, 101 DATA; others invalid
pkt_energy  in  WORD_WIDTH  energy field
pkt_destID  in  WORD_WIDTH  destination ID field
pkt_hops  in  WORD_WIDTH  hop count field
pkt_timeslot  in  WORD_WIDTH  timeslot field
en_MNI  out  1  one-cycle enable to myNodeInfo
en_FWD  out  1  one-cycle enable to forwarding unit
en_INV  out  1  one-cycle enable to invite handler
fPktType  out  3  registered packet type to consumers
energy, destinationID, hops, timeslot  out  WORD_WIDTH each  registered fields to consumers
hb_lock  out  1  1 after a heartbeat is accepted; further HBs are dropped
busy  out  1  ~pkt_ready
drop_count  out  DROP_CNT_WIDTH  saturating count of dropped packets

Behaviour:
- Reset (nrst=1 at a clk edge): state IDLE; pkt_ready=1; en_MNI=en_FWD=en_INV=0; hb_lock=0; drop_count=0; fPktType=3'b111; all field outputs 0. Reset overrides any state, including mid-SETTLE. A packet presented in the reset cycle is not accepted.
- FSM states:
  - IDLE: pkt_ready=1. Transfer occurs when pkt_valid&&pkt_ready at an edge. That edge loads all fields into output registers and goes to DECODE.
  - DECODE, 1 cycle, pkt_ready=0. Drop if type is 011, 110 or 111, or if type is 000 with hb_lock=1. A drop increments drop_count (saturates at all-ones) and returns to IDLE. Otherwise go to ISSUE.
  - ISSUE, 1 cycle: enables asserted for exactly this cycle:
    - 000: en_MNI; hb_lock set at end of cycle.
    - 001: en_MNI.
    - 100: en_MNI.
    - 010: en_INV only.
    - 101: en_MNI and en_FWD together; hb_lock cleared at end of cycle.
    - Then go to SETTLE with counter=SETTLE_CYCLES-1.
  - SETTLE: pkt_ready=0, all enables 0. Decrement each cycle; at 0 go to IDLE.
- Latency and throughput:
  - Transfer at edge k gives DECODE in cycle k..k+1 and enable high in cycle k+1..k+2.
  - Dispatched packets occupy 2+SETTLE_CYCLES cycles; pkt_ready returns high after SETTLE.
  - Dropped packets occupy 1 cycle beyond the accept cycle.
- Field outputs stay stable from the capture edge until the next accepted packet, including after drops. The consumer samples them during the en_* cycle.
- pkt_valid while pkt_ready=0 is ignored; upstream must hold it.
- Enables are never asserted outside ISSUE. At most one of en_INV/en_MNI is high; en_FWD is high only with en_MNI.

Test Plan:
- Reset then HB (type 000, hops=1, energy=16'h8000) -> en_MNI high exactly 1 cycle, 2 cycles after accept; hops=1, energy=16'h8000 on outputs; hb_lock=1; pkt_ready low 4 cycles (SETTLE_CYCLES=2).
- Second HB (hops=2, energy=16'h7FC0) while hb_lock=1 -> no enable; drop_count=1; hops output stays 1; pkt_ready back after 2 cycles.
- CHE destID=16'h000C, then INV destID=32 -> en_MNI pulse with fPktType=001; then en_INV pulse only, with fPktType=010 and destinationID=32.
- DATA type 101 destID=14, hops=3 -> en_MNI and en_FWD in the same cycle; hb_lock cleared; a following HB is dispatched, not dropped.
- Back-to-back: pkt_valid held high with 4 packets queued upstream -> each accepted only when pkt_ready=1. Type 111 is dropped. 300 invalid packets -> drop_count saturates at 8'hFF.
- Assert nrst during SETTLE after an HB -> next cycle IDLE, pkt_ready=1, hb_lock=0, fPktType=3'b111, no stray enable.
